// File: rtl/rv64_mem_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Pure declarations; no logic, no latency.
// Backpressure is not applicable to this package.
package rv64_mem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int WIDTH_DEF        = 64;
  localparam int BYTES            = WIDTH_DEF / 8;
  localparam int MEM_LATENCY_DEF  = 1;
  localparam int STARVE_LIMIT_DEF = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one access at a time.
// Latency: handshake N -> mem_en N+1 -> rsp_valid N+2+MEM_LATENCY (one-cycle pulse).
// Backpressure: ready only in IDLE/RESP; LS normally wins, fetch forced after STARVE_LIMIT LS grants; responses cannot be stalled.
module mem_port_arbiter
  import rv64_mem_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req_valid,
  output logic               if_req_ready,
  input  logic [WIDTH-1:0]   if_req_addr,
  output logic               if_rsp_valid,
  output logic [WIDTH-1:0]   if_rsp_rdata,
  input  logic               ls_req_valid,
  output logic               ls_req_ready,
  input  logic [WIDTH-1:0]   ls_req_addr,
  input  logic [WIDTH/8-1:0] ls_req_we,
  input  logic [WIDTH-1:0]   ls_req_wdata,
  output logic               ls_rsp_valid,
  output logic [WIDTH-1:0]   ls_rsp_rdata,
  output logic               mem_en,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH/8-1:0] mem_we,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               busy
);

  localparam int NB = WIDTH / 8;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [1:0]        lat_q, lat_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [NB-1:0]     we_q, we_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0]  ls_rdata_q, ls_rdata_d;

  logic accepting;
  logic starve;
  logic if_hs;
  logic ls_hs;

  // Arbitration: LS has priority unless fetch has been passed over STARVE_LIMIT times.
  // Ready is held low while reset is asserted, even though the FSM sits in IDLE.
  always_comb begin
    accepting    = rst_n && ((state_q == IDLE) || (state_q == RESP));
    starve       = (starve_q == SW'(STARVE_LIMIT));
    if_req_ready = accepting && (!ls_req_valid || starve);
    ls_req_ready = accepting && !(if_req_valid && starve);
    if_hs        = if_req_valid && if_req_ready;
    ls_hs        = ls_req_valid && ls_req_ready;
  end

  // Next-state: request capture, latency countdown and response capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (if_hs) begin
          addr_d  = if_req_addr;
          we_d    = '0;
          wdata_d = '0;
          owner_d = OWN_IF;
          state_d = ISSUE;
        end else if (ls_hs) begin
          addr_d  = ls_req_addr;
          we_d    = ls_req_we;
          wdata_d = ls_req_wdata;
          owner_d = OWN_LS;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        lat_d   = 2'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            ls_rdata_d = (we_q == '0) ? mem_rdata : '0;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Count LS wins that made a waiting fetch lose; any fetch win clears it.
    if (if_hs) begin
      starve_d = '0;
    end else if (ls_hs && if_req_valid && !starve) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers; reset drops any in-flight access without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      starve_q   <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Memory port and response outputs; byte mask is gated so it is zero off-strobe.
  always_comb begin
    mem_en       = (state_q == ISSUE);
    mem_we       = mem_en ? we_q : '0;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    busy         = (state_q == ISSUE) || (state_q == WAIT);
    if_rsp_valid = (state_q == RESP) && (owner_q == OWN_IF);
    ls_rsp_valid = (state_q == RESP) && (owner_q == OWN_LS);
    if_rsp_rdata = if_rdata_q;
    ls_rsp_rdata = ls_rdata_q;
  end

endmodule
